// File: rtl/sc_stream_encoder.sv
// Binary-to-stochastic frame encoder. Each accepted WIDTH-bit value is emitted as
// a 2^WIDTH-bit unipolar bitstream frame whose ones-count equals the value exactly.
module sc_stream_encoder #(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'h00F3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    // Right-shift Galois toggle masks for maximal-length sequences, indexed by width.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'hD008;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    localparam logic [WIDTH:0]   LAST_IDX = (WIDTH+1)'((1 << WIDTH) - 1);
    localparam logic [WIDTH:0]   CNT_ONE  = (WIDTH+1)'(1);

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] shifted;
        shifted = s >> 1;
        if (s[0]) begin
            return shifted ^ TAPS;
        end else begin
            return shifted;
        end
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             xfer_s;
    logic             last_xfer_s;
    logic             start_s;
    logic             direct_s;
    logic [WIDTH-1:0] start_val_s;
    logic [WIDTH-1:0] rng_s;

    assign in_ready_s  = !pend_full_q && !abort;
    assign accept_s    = in_valid && in_ready_s;
    assign xfer_s      = (state_q == RUN) && out_ready;
    assign last_xfer_s = xfer_s && (cnt_q == LAST_IDX);

    assign in_ready  = in_ready_s;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // State, frame datapath and registered stream outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            lfsr_q      <= SEED_W;
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state: frame start/advance, pending buffer management and abort
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        start_s     = 1'b0;
        direct_s    = 1'b0;
        start_val_s = in_data;
        if (abort) begin
            state_d     = IDLE;
            pend_full_d = 1'b0;
            lfsr_d      = SEED_W;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_full_q) begin
                        start_s     = 1'b1;
                        start_val_s = pend_q;
                        pend_full_d = 1'b0;
                    end else if (accept_s) begin
                        start_s  = 1'b1;
                        direct_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (last_xfer_s) begin
                        if (pend_full_q) begin
                            start_s     = 1'b1;
                            start_val_s = pend_q;
                            pend_full_d = 1'b0;
                        end else if (accept_s) begin
                            start_s  = 1'b1;
                            direct_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                            lfsr_d  = SEED_W;
                            cnt_d   = '0;
                        end
                    end else if (xfer_s) begin
                        cnt_d  = cnt_q + CNT_ONE;
                        lfsr_d = lfsr_step(lfsr_q);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (start_s) begin
                state_d  = RUN;
                active_d = start_val_s;
                lfsr_d   = SEED_W;
                cnt_d    = '0;
            end else begin
                active_d = active_q;
            end

            // A value not consumed straight into active lands behind any pending reload.
            if (accept_s && !direct_s) begin
                pend_d      = in_data;
                pend_full_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // Output comb: next stream bit compares the next active value against the next rng
    always_comb begin
        rng_s       = lfsr_d;
        out_valid_d = (state_d == RUN);
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        if (cnt_d == LAST_IDX) begin
            rng_s = '0;
        end else begin
            rng_s = lfsr_d;
        end
        if (out_valid_d) begin
            out_bit_d  = (active_d > rng_s);
            out_last_d = (cnt_d == LAST_IDX);
        end else begin
            out_bit_d  = 1'b0;
            out_last_d = 1'b0;
        end
    end

endmodule
